// File: rtl/audio_play_ctrl.sv
// audio_play_ctrl: paces sample reads from a shared byte memory into the left/right DAC registers.
// Build macro AUDIO_PLAY_MONO_EN: one read per period, the same sample drives both channels.
module audio_play_ctrl #(
    parameter int CLK_DIV    = 7000,
    parameter int LEFT_BASE  = 0,
    parameter int RIGHT_BASE = 2000,
    parameter int LEN        = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        loop,
    output logic        mem_rd,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic [7:0]  left,
    output logic [7:0]  right,
    output logic        busy,
    output logic        done,
    output logic        led
);

    if (CLK_DIV < 4 || CLK_DIV > 8191) begin : g_bad_clk_div
        $error("audio_play_ctrl: CLK_DIV must be in 4..8191");
    end
    if (LEN < 1 || LEN > 2048) begin : g_bad_len
        $error("audio_play_ctrl: LEN must be in 1..2048");
    end
    if (LEFT_BASE < 0 || LEFT_BASE + LEN > 4096) begin : g_bad_left_base
        $error("audio_play_ctrl: LEFT_BASE+LEN exceeds the 12-bit address space");
    end
    if (RIGHT_BASE < 0 || RIGHT_BASE + LEN > 4096) begin : g_bad_right_base
        $error("audio_play_ctrl: RIGHT_BASE+LEN exceeds the 12-bit address space");
    end

    localparam logic [12:0] PRESC_LAST   = 13'(CLK_DIV - 1);
    localparam logic [10:0] LAST_IDX     = 11'(LEN - 1);
    localparam logic [11:0] LEFT_BASE_A  = 12'(LEFT_BASE);
    localparam logic [11:0] RIGHT_BASE_A = 12'(RIGHT_BASE);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_L,
        RD_R,
        UPD
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [12:0] presc_q;
    logic [10:0] index_q;
    logic        tick;
    logic        last;
`ifndef AUDIO_PLAY_MONO_EN
    logic [7:0]  hold_q;
`endif

    assign tick = (presc_q == PRESC_LAST);
    assign last = (index_q == LAST_IDX);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && !stop) state_d = WAIT;
            WAIT: if (tick) state_d = RD_L;
`ifdef AUDIO_PLAY_MONO_EN
            RD_L: state_d = UPD;
`else
            RD_L: state_d = RD_R;
`endif
            RD_R: state_d = UPD;
            UPD:  state_d = (last && !loop) ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
        // Abort overrides every transition, including a start in the same cycle.
        if (state_q != IDLE && stop) state_d = IDLE;
    end

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = '0;
        busy     = (state_q != IDLE);
        case (state_q)
            RD_L: begin
                mem_rd   = 1'b1;
                mem_addr = LEFT_BASE_A + {1'b0, index_q};
            end
            RD_R: begin
                mem_rd   = 1'b1;
                mem_addr = RIGHT_BASE_A + {1'b0, index_q};
            end
            default: begin
                mem_rd   = 1'b0;
                mem_addr = '0;
            end
        endcase
        led = busy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            index_q <= '0;
            left    <= '0;
            right   <= '0;
            done    <= 1'b0;
`ifndef AUDIO_PLAY_MONO_EN
            hold_q  <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state_q == IDLE || stop) begin
                // Index and prescaler restart from zero on the next accepted start.
                presc_q <= '0;
                index_q <= '0;
                if (state_q != IDLE) begin
                    left  <= '0;
                    right <= '0;
                end
            end else begin
                presc_q <= tick ? '0 : presc_q + 13'd1;
`ifndef AUDIO_PLAY_MONO_EN
                if (state_q == RD_R) hold_q <= mem_data;
`endif
                if (state_q == UPD) begin
`ifdef AUDIO_PLAY_MONO_EN
                    left  <= mem_data;
                    right <= mem_data;
`else
                    left  <= hold_q;
                    right <= mem_data;
`endif
                    if (last) begin
                        index_q <= '0;
                        done    <= !loop;
                    end else begin
                        index_q <= index_q + 11'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_play_ctrl.sv
// Bench for audio_play_ctrl: timeline model of playback checked every cycle, plus directed literal checks.
module tb_audio_play_ctrl;

    localparam int CLK_DIV    = 8;
    localparam int LEN        = 4;
    localparam int LEFT_BASE  = 0;
    localparam int RIGHT_BASE = 16;
`ifdef AUDIO_PLAY_MONO_EN
    localparam bit MONO = 1'b1;
`else
    localparam bit MONO = 1'b0;
`endif
    // Edges from the read-start edge to the edge that updates left/right.
    localparam int UPD_OFS = MONO ? 2 : 3;
    localparam int FIRST   = CLK_DIV + UPD_OFS;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        loop;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data = 8'hEE;
    logic [7:0]  left;
    logic [7:0]  right;
    logic        busy;
    logic        done;
    logic        led;

    audio_play_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .LEFT_BASE (LEFT_BASE),
        .RIGHT_BASE(RIGHT_BASE),
        .LEN       (LEN)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .mem_rd  (mem_rd),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .left    (left),
        .right   (right),
        .busy    (busy),
        .done    (done),
        .led     (led)
    );

    always #5 clk = ~clk;

    // Sample memory: each byte holds its address plus 0x10; data appears the cycle after the strobe.
    always @(posedge clk) mem_data <= mem_rd ? (mem_addr[7:0] + 8'h10) : 8'hEE;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Playback model: time m_t counts edges since the accepted start; each period of CLK_DIV
    // edges reads at phase 0 (left) and 1 (right), and publishes the pair UPD_OFS edges later.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_rd = 1'b0;
    int          m_t = 0;
    int          m_idx = 0;
    int          m_ph = 0;
    logic [7:0]  m_left = '0;
    logic [7:0]  m_right = '0;
    logic [11:0] m_addr = '0;

    task automatic model_step();
        m_done = 1'b0;
        if (reset) begin
            m_busy  = 1'b0;
            m_left  = '0;
            m_right = '0;
            m_idx   = 0;
            m_t     = 0;
        end else if (m_busy && stop) begin
            m_busy  = 1'b0;
            m_left  = '0;
            m_right = '0;
        end else if (!m_busy) begin
            if (start && !stop) begin
                m_busy = 1'b1;
                m_t    = 0;
                m_idx  = 0;
            end
        end else begin
            m_t++;
            if (m_t > CLK_DIV && (m_t % CLK_DIV) == UPD_OFS) begin
                m_left  = 8'(LEFT_BASE + m_idx + 16);
                m_right = MONO ? m_left : 8'(RIGHT_BASE + m_idx + 16);
                if (m_idx == LEN - 1) begin
                    if (loop) m_idx = 0;
                    else begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end else begin
                    m_idx++;
                end
            end
        end
        m_ph   = m_t % CLK_DIV;
        m_rd   = m_busy && m_t >= CLK_DIV && (m_ph == 0 || (!MONO && m_ph == 1));
        m_addr = !m_rd ? 12'd0 : (m_ph == 0 ? 12'(LEFT_BASE + m_idx) : 12'(RIGHT_BASE + m_idx));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #2;
            if (cmp_en) begin
                check("cyc_left", left, m_left);
                check("cyc_right", right, m_right);
                check("cyc_busy", busy, m_busy);
                check("cyc_led", led, m_busy);
                check("cyc_done", done, m_done);
                check("cyc_mem_rd", mem_rd, m_rd);
                check("cyc_mem_addr", mem_addr, m_addr);
                if (done === 1'b1) done_cnt++;
                if (mem_rd === 1'b1) rd_cnt++;
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_pair(input string name, input logic [7:0] l, input logic [7:0] r_stereo);
        check({name, "_left"}, left, l);
        check({name, "_right"}, right, MONO ? l : r_stereo);
    endtask

    int d0;
    int r0;

    initial begin
        reset = 1'b1;
        start = 1'b1;
        stop  = 1'b0;
        loop  = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_led", led, 0);
        check("rst_done", done, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check_pair("rst", 8'h00, 8'h00);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single pass, no loop.
        d0 = done_cnt;
        pulse_start();
        wait_n(FIRST - 1);
        check_pair("play_pre", 8'h00, 8'h00);
        wait_n(1);
        check_pair("play_s0", 8'h10, 8'h20);
        check("play_busy", busy, 1);
        wait_n(CLK_DIV);
        check_pair("play_s1", 8'h11, 8'h21);
        wait_n(CLK_DIV);
        check_pair("play_s2", 8'h12, 8'h22);
        wait_n(CLK_DIV);
        check_pair("play_s3", 8'h13, 8'h23);
        check("play_done", done, 1);
        check("play_busy_end", busy, 0);
        check("play_led_end", led, 0);
        wait_n(1);
        check("play_done_pulse", done, 0);
        check_pair("play_hold", 8'h13, 8'h23);
        check("play_done_count", done_cnt - d0, 1);

        // Looping playback over ten periods.
        loop = 1'b1;
        d0 = done_cnt;
        pulse_start();
        wait_n(FIRST);
        check_pair("loop_s0", 8'h10, 8'h20);
        wait_n(3 * CLK_DIV);
        check_pair("loop_s3", 8'h13, 8'h23);
        wait_n(CLK_DIV);
        check_pair("loop_wrap", 8'h10, 8'h20);
        wait_n(5 * CLK_DIV);
        check_pair("loop_s9", 8'h11, 8'h21);
        check("loop_busy", busy, 1);
        check("loop_no_done", done_cnt - d0, 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop = 1'b0;
        check_pair("loop_stop", 8'h00, 8'h00);
        check("loop_stop_busy", busy, 0);

        // Abort during the right-channel read of the second period.
        d0 = done_cnt;
        pulse_start();
        wait_n(2 * CLK_DIV + 1);
        check_pair("abort_pre", 8'h10, 8'h20);
        check("abort_rd", mem_rd, MONO ? 0 : 1);
        check("abort_addr", mem_addr, MONO ? 0 : 17);
        r0 = rd_cnt;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_pair("abort", 8'h00, 8'h00);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        wait_n(3 * CLK_DIV);
        check("abort_no_reads", rd_cnt - r0, 0);
        check("abort_no_done", done_cnt - d0, 0);

        // Start and stop together from idle, then start re-pulsed while busy.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("coll_busy", busy, 0);
        wait_n(FIRST + 2);
        check("coll_idle", busy, 0);
        check("coll_reads", rd_cnt - r0, 0);
        d0 = done_cnt;
        pulse_start();
        wait_n(5);
        pulse_start();
        wait_n(2);
        pulse_start();
        wait_n(FIRST - 9);
        check_pair("coll_s0", 8'h10, 8'h20);
        wait_n(3);
        pulse_start();
        wait_n(4);
        check_pair("coll_s1", 8'h11, 8'h21);
        wait_n(2 * CLK_DIV);
        check_pair("coll_s3", 8'h13, 8'h23);
        check("coll_done", done, 1);
        check("coll_done_count", done_cnt - d0, 1);

        // Reset while waiting between samples, then replay from the start of the buffer.
        pulse_start();
        wait_n(FIRST + 2);
        check_pair("mid_pre", 8'h10, 8'h20);
        reset = 1'b1;
        @(negedge clk);
        check_pair("mid_rst", 8'h00, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_led", led, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd", mem_rd, 0);
        check("mid_rst_addr", mem_addr, 0);
        reset = 1'b0;
        @(negedge clk);
        pulse_start();
        wait_n(FIRST);
        check_pair("mid_replay", 8'h10, 8'h20);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_n(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_play_ctrl.md
AUDIO_PLAY_CTRL -- requirements
Module: audio_play_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 7000: clk cycles per stereo sample period; legal range 4..8191.
REQ-002 SHALL have parameter LEFT_BASE, default 0: first left-channel sample address.
REQ-003 SHALL have parameter RIGHT_BASE, default 2000: first right-channel sample address.
REQ-004 SHALL have parameter LEN, default 2000: samples per channel; legal range 1..2048.
REQ-005 SHALL have port clk  in  1: single clock, 14 MHz; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-007 SHALL have port start  in  1: one-cycle request to begin playback from index 0.
REQ-008 SHALL have port stop  in  1: one-cycle request to abort playback.
REQ-009 SHALL have port loop  in  1: level; 1 means wrap to index 0 at end of buffer, 0 means finish.
REQ-010 SHALL have port mem_rd  out  1: read strobe to the shared sample memory.
REQ-011 SHALL have port mem_addr  out  12: read address, valid while mem_rd=1.
REQ-012 SHALL have port mem_data  in  8: read data, valid exactly one cycle after mem_rd.
REQ-013 SHALL have ports left and right  out  8 each: current sample for each DAC channel.
REQ-014 SHALL have port busy  out  1: high while playback is in progress.
REQ-015 SHALL have port done  out  1: one-cycle pulse on normal (non-loop) completion.
REQ-016 SHALL have port led  out  1: equal to busy.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, RD_L, RD_R and UPD.
REQ-018 IDLE with start=1 and stop=0 SHALL go to WAIT, clear index and prescaler, and set busy.
REQ-019 Prescaler SHALL count 0..CLK_DIV-1 in all non-IDLE states; tick = count==CLK_DIV-1; WAIT with tick SHALL go to RD_L.
REQ-020 RD_L SHALL drive mem_rd=1, mem_addr=LEFT_BASE+index, and go to RD_R.
REQ-021 RD_R SHALL drive mem_rd=1, mem_addr=RIGHT_BASE+index, capture mem_data into a left hold register, and go to UPD.
REQ-022 UPD SHALL capture mem_data as the right sample and load left (from hold) and right in the same edge, so both change together 4 cycles after tick.
REQ-023 UPD at index<LEN-1 SHALL increment index and return to WAIT.
REQ-024 UPD at index=LEN-1 with loop=1 SHALL set index to 0 and return to WAIT, with no done pulse.
REQ-025 UPD at index=LEN-1 with loop=0 SHALL pulse done for one cycle, go to IDLE and clear busy; left/right SHALL keep the last sample.
REQ-026 stop=1 in any non-IDLE state SHALL go to IDLE on the next edge, drive left=right=0, clear busy, assert no done, and abandon any in-flight read.
REQ-027 stop and start in the same cycle SHALL behave as stop; start while busy SHALL be ignored.
REQ-028 mem_rd SHALL be 0 in IDLE, WAIT and UPD; mem_addr SHALL be 0 whenever mem_rd=0.
REQ-029 Address sums SHALL be computed at 12 bits; LEFT_BASE+LEN and RIGHT_BASE+LEN SHALL be at most 4096 (checked at elaboration).

Reset
REQ-030 With reset=1, the next edge SHALL set state IDLE, index=0, prescaler=0, left=right=0, mem_rd=0, mem_addr=0, busy=0, done=0 and led=0.
REQ-031 reset SHALL take priority over start and stop.

Configuration
REQ-032 With AUDIO_PLAY_MONO_EN defined, RD_R SHALL be skipped: RD_L goes directly to UPD, UPD drives mem_data to both left and right, and only LEFT_BASE reads occur.
REQ-033 Without AUDIO_PLAY_MONO_EN, stereo behaviour per REQ-020..REQ-022 SHALL apply.

Verification
Test parameters: CLK_DIV=8, LEN=4, LEFT_BASE=0, RIGHT_BASE=16; memory holds addr+8'h10.
REQ-034 Stereo playback: reset, start, loop=0 -> left/right = 10/20, 11/21, 12/22, 13/23 at 8-cycle spacing; done pulses once; busy and led fall.
REQ-035 Loop: loop=1 for 10 sample periods -> after index 3 the outputs wrap to 10/20; no done pulse.
REQ-036 Abort: stop in the cycle of the RD_R read -> next cycle left=right=0, busy=0, no done, no further mem_rd.
REQ-037 Collisions: start+stop in the same cycle from IDLE -> stays IDLE; start re-pulsed while busy -> sequence unchanged.
REQ-038 Mid-play reset: reset asserted during WAIT -> all outputs 0 next edge; a subsequent start replays from 10/20.
REQ-039 Mono build: define AUDIO_PLAY_MONO_EN -> left=right=10,11,12,13; no read at addresses 16..19.
